// File: rtl/store_pkg.sv
// Shared encodings for the store unit: request sizes, FSM states, base masks.
package store_pkg;

    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } state_e;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // Byte-enable pattern for a store of the given size at lane 0.
    function automatic logic [3:0] base_mask(input size_e sz);
        case (sz)
            SZ_BYTE: return MASK_BYTE;
            SZ_HALF: return MASK_HALF;
            SZ_WORD: return MASK_WORD;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Lane alignment: positions store data and byte enables across two adjacent
// 32-bit words, and flags when the upper word is touched.
module store_lane_align
    import store_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [7:0]  mask8,
    output logic [63:0] data64,
    output logic        split,
    output logic        legal
);

    logic [3:0]  mask;
    logic [31:0] rep;

    // Replicate the right-justified operand, then shift mask and data by lane offset.
    always_comb begin
        mask = base_mask(size_e'(size));
        rep  = data;
        case (size_e'(size))
            SZ_BYTE: rep = {4{data[7:0]}};
            SZ_HALF: rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        mask8  = {4'b0000, mask} << offset;
        data64 = {32'h0000_0000, rep} << {offset, 3'b000};
        split  = |mask8[7:4];
        legal  = (size_e'(size) != SZ_ILL);
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: forms the effective address, splits word-crossing stores into
// two byte-masked beats and drives them over a valid/ready write port.
module store_unit
    import store_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [11:0]       req_offset,
    input  logic [ADDR_W-1:0] req_data,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    output logic [3:0]        mem_we,
    output logic              done,
    output logic              err
);

    state_e state, state_next;

    logic [ADDR_W-1:0] ea;
    logic [7:0]        mask8;
    logic [63:0]       data64;
    logic              split;
    logic              legal;

    logic              split_q;
    logic [ADDR_W-1:0] b1_addr;
    logic [ADDR_W-1:0] b1_wdata;
    logic [3:0]        b1_we;

    logic              idle;
    logic              accept;
    logic              reject;

    assign ea        = req_base + {{(ADDR_W-12){req_offset[11]}}, req_offset};
    assign idle      = (state == ST_IDLE);
    assign req_ready = idle;
    assign accept    = idle && req_valid && legal;
    assign reject    = idle && req_valid && !legal;

    store_lane_align u_align (
        .offset (ea[1:0]),
        .size   (req_size),
        .data   (req_data),
        .mask8  (mask8),
        .data64 (data64),
        .split  (split),
        .legal  (legal)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state decode: beats advance only on a memory handshake.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (req_valid && legal) state_next = ST_BEAT0;
            ST_BEAT0: if (mem_ready) state_next = split_q ? ST_BEAT1 : ST_IDLE;
            ST_BEAT1: if (mem_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Beat registers and registered port outputs; beat1 is staged at accept time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            split_q   <= 1'b0;
            b1_addr   <= '0;
            b1_wdata  <= '0;
            b1_we     <= '0;
        end else begin
            done <= 1'b0;
            err  <= reject;
            if (accept) begin
                mem_valid <= 1'b1;
                mem_addr  <= {ea[ADDR_W-1:2], 2'b00};
                mem_wdata <= data64[31:0];
                mem_we    <= mask8[3:0];
                split_q   <= split;
                b1_addr   <= {ea[ADDR_W-1:2], 2'b00} + 32'd4;
                b1_wdata  <= data64[63:32];
                b1_we     <= mask8[7:4];
            end else if (mem_valid && mem_ready) begin
                if (state == ST_BEAT0 && split_q) begin
                    mem_addr  <= b1_addr;
                    mem_wdata <= b1_wdata;
                    mem_we    <= b1_we;
                end else begin
                    mem_valid <= 1'b0;
                    mem_we    <= '0;
                    done      <= 1'b1;
                end
            end
        end
    end

endmodule
